// File: rtl/crypt_pkg.sv
// Shared types and constants for the LFSR stream-cipher message format.
package crypt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARMED,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_FETCH,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Parameter block sits directly above the output half of memory
  localparam logic [7:0] ADDR_PRE      = 8'd61;
  localparam logic [7:0] ADDR_TAP      = 8'd62;
  localparam logic [7:0] ADDR_SEED     = 8'd63;
  localparam logic [7:0] DST_BASE_ADDR = 8'd64;

  // Pad character used before and after the plaintext window
  localparam logic [7:0] SPACE = 8'h20;

  // Maximal-length feedback patterns the decryptor knows how to search
  localparam logic [7:0] LEGAL_TAPS [9] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B
  };

  // Seven cipher bits plus their even-fold parity in bit 7
  function automatic logic [7:0] parity_tag(input logic [6:0] bits);
    return {^bits, bits};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// Seven-bit Fibonacci LFSR, shared definition with the decryptor.
module lfsr7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       step,
  input  logic [6:0] tap,
  output logic [6:0] q
);

  logic [6:0] next_q;

  // Shift left, feeding back the parity of the tapped bits into bit 0
  always_comb begin
    next_q = {q[5:0], ^(q & tap)};
  end

  // Load wins over step; otherwise the state holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 7'h00;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= next_q;
    end
  end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Golden producer of encrypted, parity-tagged messages for the program-3 decryptor.
module lfsr_encrypt_engine
  import crypt_pkg::*;
#(
  parameter int MSG_LEN  = 64,
  parameter int SRC_MAX  = 61,
  parameter int DST_BASE = 64
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_addr,
  input  logic [7:0] dm_rd_data,
  output logic       dm_wr_en,
  output logic [7:0] dm_wr_data
);

  state_t     state;
  logic [5:0] pre;
  logic [6:0] tap;
  logic [6:0] idx;
  logic [6:0] lfsr_q;
  logic [6:0] src;
  logic       pad;
  logic       last;
  logic [6:0] seed;
  logic [7:0] plain;
  logic [7:0] cipher;
  logic       load_seed;
  logic       step_lfsr;
  logic       unused_plain7;

  // Source index is i - pre in 7-bit two's complement; negative or past the
  // plaintext window means this byte is a pad character
  always_comb begin
    src = idx - {1'b0, pre};
    pad = src[6] | (src >= 7'(SRC_MAX));
    last = (idx == 7'(MSG_LEN - 1));
  end

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  always_comb begin
    seed = (dm_rd_data[6:0] == 7'h00) ? 7'h01 : dm_rd_data[6:0];
    plain = pad ? SPACE : dm_rd_data;
    cipher = parity_tag(plain[6:0] ^ lfsr_q);
    unused_plain7 = plain[7];
    load_seed = (state == ST_P3);
    step_lfsr = (state == ST_WRITE);
  end

  lfsr7 u_lfsr (
    .clk   (clk),
    .rst_n (init),
    .load  (load_seed),
    .seed  (seed),
    .step  (step_lfsr),
    .tap   (tap),
    .q     (lfsr_q)
  );

  // Sequencer: arm on req high, launch on req low, fetch params, then alternate FETCH/WRITE
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      pre   <= 6'd0;
      tap   <= 7'd0;
      idx   <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_ARMED;
            ack   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!req) state <= ST_P0;
        end
        ST_P0: state <= ST_P1;
        ST_P1: begin
          pre   <= dm_rd_data[5:0];
          state <= ST_P2;
        end
        ST_P2: begin
          tap   <= dm_rd_data[6:0];
          state <= ST_P3;
        end
        ST_P3: begin
          idx   <= 7'd0;
          state <= ST_FETCH;
        end
        ST_FETCH: state <= ST_WRITE;
        ST_WRITE: begin
          idx <= idx + 7'd1;
          if (last) begin
            state <= ST_DONE;
            ack   <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (req) begin
            state <= ST_ARMED;
            ack   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decoded from registered state; write data must follow the
  // synchronous read that lands in the same WRITE cycle
  always_comb begin
    dm_addr    = 8'h00;
    dm_wr_en   = 1'b0;
    dm_wr_data = 8'h00;
    case (state)
      ST_P0:    dm_addr = ADDR_PRE;
      ST_P1:    dm_addr = ADDR_TAP;
      ST_P2:    dm_addr = ADDR_SEED;
      ST_FETCH: if (!pad) dm_addr = {1'b0, src};
      ST_WRITE: begin
        dm_addr    = 8'(DST_BASE) + {1'b0, idx};
        dm_wr_en   = 1'b1;
        dm_wr_data = cipher;
      end
      default: ;
    endcase
  end

endmodule
